// File: rtl/bit_stream_serializer.sv
// ---------------------------------------------------------------------------
// bit_stream_serializer
//
// Feeds the serial sequence detector. Parallel words arrive over a
// valid/ready handshake, are held in a 2-entry FIFO, and are shifted out one
// bit per clock on `w`. Between words `w` sits at IDLE_BIT so the detector
// always sees a defined level.
//
// Handshake: a word transfers on a rising edge where data_valid and
// data_ready are both high. data_ready depends only on registered state
// (and reset), never on data_valid, so the producer may hold data_valid
// high indefinitely. data_in is only sampled on a transferring edge.
//
// Ports:
//   clock       rising-edge clock
//   reset       synchronous, active-high reset
//   data_in     parallel word (WIDTH bits)
//   data_valid  producer offers data_in
//   data_ready  a FIFO slot is free this cycle
//   w           serial bit stream (registered)
//   bit_valid   w carries a data bit (registered)
//   frame_start w carries bit 0 of a word (registered)
//   busy        a word is shifting or the FIFO holds a word
//   words_sent  wrapping count of fully transmitted words
// ---------------------------------------------------------------------------
module bit_stream_serializer #(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b1,
   parameter bit IDLE_BIT  = 1'b0
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] data_in,
   input  logic             data_valid,
   output logic             data_ready,
   output logic             w,
   output logic             bit_valid,
   output logic             frame_start,
   output logic             busy,
   output logic [15:0]      words_sent
);

   localparam int IW = $clog2(WIDTH);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] buf0;      // FIFO head
   logic [WIDTH-1:0] buf1;      // FIFO second entry
   logic [1:0]       count;
   logic [WIDTH-1:0] sreg;      // bits still to send, next one at bit 0
   logic [IW-1:0]    idx;       // index of the bit currently on w
   logic [WIDTH-1:0] head_ord;  // head word reordered so bit 0 goes out first
   logic             push;
   logic             pop;
   logic             last_bit;

   // Reorder a word so the shifter can always transmit from bit 0 upward.
   function automatic logic [WIDTH-1:0] tx_order(input logic [WIDTH-1:0] word);
      logic [WIDTH-1:0] r;
      r = word;
      if (MSB_FIRST) begin
         for (int i = 0; i < WIDTH; i++) begin
            r[i] = word[WIDTH-1-i];
         end
      end
      return r;
   endfunction

   assign data_ready = (count != 2'd2) & ~reset;
   assign push       = data_valid & data_ready;
   assign last_bit   = (state == SHIFT) && (idx == IW'(WIDTH-1));
   // The head is taken either from idle or on the edge retiring the last
   // bit, which gives back-to-back words with no idle gap.
   assign pop        = (count != 2'd0) && ((state == IDLE) || last_bit);
   assign busy       = (state == SHIFT) | (count != 2'd0);
   assign head_ord   = tx_order(buf0);

   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= IDLE;
         buf0        <= '0;
         buf1        <= '0;
         count       <= 2'd0;
         sreg        <= '0;
         idx         <= '0;
         w           <= IDLE_BIT;
         bit_valid   <= 1'b0;
         frame_start <= 1'b0;
         words_sent  <= 16'd0;
      end else begin
         // FIFO update. Push with pop only happens at count 1 (a full FIFO
         // never accepts), so the new word simply becomes the head.
         case ({push, pop})
            2'b10: begin
               if (count == 2'd0) buf0 <= data_in;
               else               buf1 <= data_in;
               count <= count + 2'd1;
            end
            2'b01: begin
               buf0  <= buf1;
               count <= count - 2'd1;
            end
            2'b11: begin
               buf0 <= data_in;
            end
            default: ;
         endcase

         // Shifter
         frame_start <= 1'b0;
         if ((state == SHIFT) && !last_bit) begin
            w    <= sreg[0];
            sreg <= sreg >> 1;
            idx  <= idx + 1'b1;
         end else if (pop) begin
            w           <= head_ord[0];
            sreg        <= head_ord >> 1;
            idx         <= '0;
            bit_valid   <= 1'b1;
            frame_start <= 1'b1;
            state       <= SHIFT;
         end else if (last_bit) begin
            w         <= IDLE_BIT;
            bit_valid <= 1'b0;
            idx       <= '0;
            state     <= IDLE;
         end

         if (last_bit) begin
            words_sent <= words_sent + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_bit_stream_serializer.sv
// ---------------------------------------------------------------------------
// tb_bit_stream_serializer
//
// Three instances: u_a (MSB first, idle 0), u_b (LSB first, idle 0) and
// u_c (MSB first, idle 1). Inputs are driven and outputs sampled on the
// falling edge; the DUT acts on the rising edge.
// ---------------------------------------------------------------------------
module tb_bit_stream_serializer;

   // ---------------- clock / reset ----------------
   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;

   // ---------------- instance a ----------------
   logic [7:0]  a_din   = 8'h00;
   logic        a_valid = 1'b0;
   logic        a_ready, a_w, a_bv, a_fs, a_busy;
   logic [15:0] a_ws;

   bit_stream_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u_a (
      .clock(clock), .reset(reset), .data_in(a_din), .data_valid(a_valid),
      .data_ready(a_ready), .w(a_w), .bit_valid(a_bv), .frame_start(a_fs),
      .busy(a_busy), .words_sent(a_ws)
   );

   // ---------------- instance b ----------------
   logic [7:0]  b_din   = 8'h00;
   logic        b_valid = 1'b0;
   logic        b_ready, b_w, b_bv, b_fs, b_busy;
   logic [15:0] b_ws;

   bit_stream_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) u_b (
      .clock(clock), .reset(reset), .data_in(b_din), .data_valid(b_valid),
      .data_ready(b_ready), .w(b_w), .bit_valid(b_bv), .frame_start(b_fs),
      .busy(b_busy), .words_sent(b_ws)
   );

   // ---------------- instance c ----------------
   logic [7:0]  c_din   = 8'h00;
   logic        c_valid = 1'b0;
   logic        c_ready, c_w, c_bv, c_fs, c_busy;
   logic [15:0] c_ws;

   bit_stream_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b1)) u_c (
      .clock(clock), .reset(reset), .data_in(c_din), .data_valid(c_valid),
      .data_ready(c_ready), .w(c_w), .bit_valid(c_bv), .frame_start(c_fs),
      .busy(c_busy), .words_sent(c_ws)
   );

   // ---------------- driver tasks ----------------
   task do_reset();
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
   endtask

   // ---------------- tests ----------------
   task test_reset();
      // reset is high from time 0; first rising edge applies it
      @(negedge clock);
      checks++;
      if (a_ready !== 1'b0) begin
         errors++; $display("FAIL reset_ready got %b want 0", a_ready);
      end
      checks++;
      if ({a_w, a_bv, a_fs, a_busy, a_ws} !== {4'b0000, 16'h0000}) begin
         errors++;
         $display("FAIL reset_state got w=%b bv=%b fs=%b busy=%b ws=%h want 0,0,0,0,0000",
                  a_w, a_bv, a_fs, a_busy, a_ws);
      end
      checks++;
      if ({c_w, c_bv} !== 2'b10) begin
         errors++; $display("FAIL reset_idle1 got w=%b bv=%b want 1,0", c_w, c_bv);
      end
      reset = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clock);
         checks++;
         if ({a_w, a_bv, a_fs, a_ready, a_busy, a_ws} !== {5'b00010, 16'h0000}) begin
            errors++;
            $display("FAIL idle_cycle %0d got w=%b bv=%b fs=%b rdy=%b busy=%b ws=%h want 0,0,0,1,0,0000",
                     i, a_w, a_bv, a_fs, a_ready, a_busy, a_ws);
         end
      end
   endtask

   task test_single_word();
      logic [7:0] exp_bits;
      exp_bits = 8'b1011_0011;   // 0xB3, MSB first
      @(negedge clock);
      a_din   = 8'hB3;
      a_valid = 1'b1;
      checks++;
      if (a_ready !== 1'b1) begin
         errors++; $display("FAIL single_ready got %b want 1", a_ready);
      end
      @(negedge clock);          // edge N has accepted the word
      a_valid = 1'b0;
      a_din   = 8'hFF;           // must not disturb the buffered word
      checks++;
      if ({a_busy, a_bv, a_w} !== 3'b100) begin
         errors++; $display("FAIL single_pre got busy=%b bv=%b w=%b want 1,0,0", a_busy, a_bv, a_w);
      end
      for (int k = 0; k < 8; k++) begin
         @(negedge clock);
         checks++;
         if ({a_w, a_bv, a_fs} !== {exp_bits[7-k], 1'b1, (k == 0)}) begin
            errors++;
            $display("FAIL single_bit %0d got w=%b bv=%b fs=%b want %b,1,%b",
                     k, a_w, a_bv, a_fs, exp_bits[7-k], (k == 0));
         end
      end
      @(negedge clock);          // after edge N+9
      checks++;
      if ({a_w, a_bv, a_busy, a_ws} !== {3'b000, 16'h0001}) begin
         errors++;
         $display("FAIL single_done got w=%b bv=%b busy=%b ws=%h want 0,0,0,0001",
                  a_w, a_bv, a_busy, a_ws);
      end
   endtask

   task test_back_to_back();
      logic [7:0]  words [3];
      logic [23:0] exp_stream;
      int i, j, first, last, bv_cnt, nr_cnt, fs_n, fs0, fs1, fs2;
      words[0] = 8'h81; words[1] = 8'h7E; words[2] = 8'hFF;
      exp_stream = 24'h817EFF;
      i = 0; j = 0; first = -1; last = -1; bv_cnt = 0; nr_cnt = 0;
      fs_n = 0; fs0 = -1; fs1 = -1; fs2 = -1;
      do_reset();
      for (int cyc = 0; cyc < 40; cyc++) begin
         @(negedge clock);
         if (a_bv) begin
            if (first < 0) first = cyc;
            last = cyc;
            bv_cnt++;
            if (j < 24) begin
               checks++;
               if (a_w !== exp_stream[23-j]) begin
                  errors++; $display("FAIL b2b_bit %0d got %b want %b", j, a_w, exp_stream[23-j]);
               end
            end
            j++;
         end
         checks++;
         if (a_fs && !a_bv) begin
            errors++; $display("FAIL b2b_fs_bv cyc %0d got fs=1 bv=0 want bv=1", cyc);
         end
         if (a_fs) begin
            if (fs_n == 0) fs0 = cyc;
            else if (fs_n == 1) fs1 = cyc;
            else if (fs_n == 2) fs2 = cyc;
            fs_n++;
         end
         if (!a_ready) nr_cnt++;
         if (i < 3) begin
            a_valid = 1'b1;
            a_din   = words[i];
            if (a_ready) i++;
         end else begin
            a_valid = 1'b0;
         end
      end
      a_valid = 1'b0;
      checks++;
      if (first !== 2 || bv_cnt !== 24 || (last - first) !== 23) begin
         errors++;
         $display("FAIL b2b_span got first=%0d cnt=%0d last=%0d want 2,24,25", first, bv_cnt, last);
      end
      checks++;
      if (fs_n !== 3 || fs0 !== 2 || fs1 !== 10 || fs2 !== 18) begin
         errors++;
         $display("FAIL b2b_frames got n=%0d at %0d,%0d,%0d want 3 at 2,10,18", fs_n, fs0, fs1, fs2);
      end
      checks++;
      if (nr_cnt !== 7) begin
         errors++; $display("FAIL b2b_not_ready got %0d cycles want 7", nr_cnt);
      end
      checks++;
      if ({a_ws, a_busy, a_w} !== {16'h0003, 2'b00}) begin
         errors++; $display("FAIL b2b_done got ws=%h busy=%b w=%b want 0003,0,0", a_ws, a_busy, a_w);
      end
   endtask

   task test_lsb_first();
      logic [7:0]  words [2];
      logic [15:0] exp_stream;
      int i, j, first, last, bv_cnt, fs_n;
      words[0] = 8'h01; words[1] = 8'h80;
      exp_stream = 16'b10000000_00000001;   // read from bit 15 down
      i = 0; j = 0; first = -1; last = -1; bv_cnt = 0; fs_n = 0;
      for (int cyc = 0; cyc < 30; cyc++) begin
         @(negedge clock);
         if (b_bv) begin
            if (first < 0) first = cyc;
            last = cyc;
            bv_cnt++;
            if (j < 16) begin
               checks++;
               if (b_w !== exp_stream[15-j]) begin
                  errors++; $display("FAIL lsb_bit %0d got %b want %b", j, b_w, exp_stream[15-j]);
               end
            end
            j++;
         end
         if (b_fs) fs_n++;
         if (i < 2) begin
            b_valid = 1'b1;
            b_din   = words[i];
            if (b_ready) i++;
         end else begin
            b_valid = 1'b0;
         end
      end
      b_valid = 1'b0;
      checks++;
      if (first !== 2 || bv_cnt !== 16 || (last - first) !== 15 || fs_n !== 2) begin
         errors++;
         $display("FAIL lsb_span got first=%0d cnt=%0d last=%0d fs=%0d want 2,16,17,2",
                  first, bv_cnt, last, fs_n);
      end
      checks++;
      if ({b_ws, b_busy} !== {16'h0002, 1'b0}) begin
         errors++; $display("FAIL lsb_done got ws=%h busy=%b want 0002,0", b_ws, b_busy);
      end
   endtask

   task test_reset_mid_word();
      logic [7:0] exp_bits;
      exp_bits = 8'b1010_1010;   // 0xAA
      @(negedge clock);
      a_din = 8'hAA; a_valid = 1'b1;
      @(negedge clock);          // AA accepted
      a_din = 8'h55; a_valid = 1'b1;
      checks++;
      if (a_ready !== 1'b1) begin
         errors++; $display("FAIL mid_ready1 got %b want 1", a_ready);
      end
      for (int k = 0; k < 5; k++) begin
         @(negedge clock);
         a_valid = 1'b0;
         checks++;
         if ({a_w, a_bv} !== {exp_bits[7-k], 1'b1}) begin
            errors++; $display("FAIL mid_bit %0d got w=%b bv=%b want %b,1", k, a_w, a_bv, exp_bits[7-k]);
         end
      end
      checks++;
      if ({a_busy, a_ws} !== {1'b1, 16'h0003}) begin
         errors++; $display("FAIL mid_pre got busy=%b ws=%h want 1,0003", a_busy, a_ws);
      end
      reset = 1'b1;              // bit 4 is on w now
      #1;
      checks++;
      if (a_ready !== 1'b0) begin
         errors++; $display("FAIL mid_ready_in_reset got %b want 0", a_ready);
      end
      @(negedge clock);
      reset = 1'b0;
      #1;
      checks++;
      if ({a_w, a_bv, a_fs, a_busy, a_ready, a_ws} !== {5'b00001, 16'h0000}) begin
         errors++;
         $display("FAIL mid_after got w=%b bv=%b fs=%b busy=%b rdy=%b ws=%h want 0,0,0,0,1,0000",
                  a_w, a_bv, a_fs, a_busy, a_ready, a_ws);
      end
      for (int i = 0; i < 20; i++) begin
         @(negedge clock);
         checks++;
         if ({a_w, a_bv, a_busy} !== 3'b000) begin
            errors++; $display("FAIL mid_stale cyc %0d got w=%b bv=%b busy=%b want 0,0,0", i, a_w, a_bv, a_busy);
         end
      end
   endtask

   task test_idle_one_wrap();
      logic [7:0]  words [2];
      logic [15:0] exp_ws [2];
      words[0] = 8'h00; words[1] = 8'h3C;
      exp_ws[0] = 16'hFFFF; exp_ws[1] = 16'h0000;
      @(negedge clock);
      force u_c.words_sent = 16'hFFFE;
      @(negedge clock);
      release u_c.words_sent;
      @(negedge clock);
      checks++;
      if ({c_ws, c_w, c_bv, c_ready} !== {16'hFFFE, 3'b101}) begin
         errors++; $display("FAIL wrap_preload got ws=%h w=%b bv=%b rdy=%b want fffe,1,0,1",
                            c_ws, c_w, c_bv, c_ready);
      end
      for (int n = 0; n < 2; n++) begin
         c_din = words[n]; c_valid = 1'b1;
         @(negedge clock);
         c_valid = 1'b0;
         checks++;
         if ({c_w, c_bv} !== 2'b10) begin
            errors++; $display("FAIL wrap_pre %0d got w=%b bv=%b want 1,0", n, c_w, c_bv);
         end
         for (int k = 0; k < 8; k++) begin
            @(negedge clock);
            checks++;
            if ({c_w, c_bv, c_fs} !== {words[n][7-k], 1'b1, (k == 0)}) begin
               errors++;
               $display("FAIL wrap_bit %0d.%0d got w=%b bv=%b fs=%b want %b,1,%b",
                        n, k, c_w, c_bv, c_fs, words[n][7-k], (k == 0));
            end
         end
         for (int g = 0; g < 3; g++) begin
            @(negedge clock);
            checks++;
            if ({c_w, c_bv, c_busy, c_ws} !== {3'b100, exp_ws[n]}) begin
               errors++;
               $display("FAIL wrap_gap %0d.%0d got w=%b bv=%b busy=%b ws=%h want 1,0,0,%h",
                        n, g, c_w, c_bv, c_busy, c_ws, exp_ws[n]);
            end
         end
      end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      test_single_word();
      test_back_to_back();
      test_lsb_first();
      test_reset_mid_word();
      test_idle_one_wrap();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

endmodule
